// File: rtl/mx8_rr_arbiter_if.sv
// mx8_rr_arbiter_if
// Bundles the requester-side bus (requests plus the eight 4-bit data words)
// and the consumer-side bus (grant, mux selects, registered word, strobes)
// of the shared 8-to-1 4-bit mux arbiter.
// The arbiter attaches through the slave modport. Whatever drives requests
// and consumes the selected word attaches through the master modport.
// Optional feature macro: MX8_ARB_LOCK_EN adds the 'lock' signal, which
// lets the current owner keep the mux past the normal beat limit.
interface mx8_rr_arbiter_if;

  // Requester side: one request bit and one data word per source (0=a .. 7=h)
  logic [7:0] req;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] c;
  logic [3:0] d;
  logic [3:0] e;
  logic [3:0] f;
  logic [3:0] g;
  logic [3:0] h;
`ifdef MX8_ARB_LOCK_EN
  logic       lock;
`endif

  // Consumer side: registered arbitration results and the transferred word
  logic [7:0] grant;
  logic       s2;
  logic       s1;
  logic       s0;
  logic [3:0] y;
  logic       y_valid;
  logic       busy;

  modport master (
    output req, a, b, c, d, e, f, g, h,
`ifdef MX8_ARB_LOCK_EN
    output lock,
`endif
    input  grant, s2, s1, s0, y, y_valid, busy
  );

  modport slave (
    input  req, a, b, c, d, e, f, g, h,
`ifdef MX8_ARB_LOCK_EN
    input  lock,
`endif
    output grant, s2, s1, s0, y, y_valid, busy
  );

endinterface

// File: rtl/mx8_rr_arbiter.sv
// mx8_rr_arbiter
// Round-robin arbiter that shares one 8-to-1, 4-bit mux among eight
// requesters. It picks a winner starting from a rotating pointer and drives
// the mux selects. It then registers one selected word per cycle with a
// valid strobe. Each tenure is limited to HOLD_MAX beats (1..15), so one
// source cannot starve the others.
// Optional feature macro: MX8_ARB_LOCK_EN. When it is defined, a 'lock'
// input holds the mux for the current owner until its request drops.
// All state is reset synchronously by an active-high 'reset'.

// Plain 8-to-1 multiplexer of 4-bit words, select = {s2,s1,s0}
module mx8_4bits (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [3:0] c_i,
  input  logic [3:0] d_i,
  input  logic [3:0] e_i,
  input  logic [3:0] f_i,
  input  logic [3:0] g_i,
  input  logic [3:0] h_i,
  input  logic       s2_i,
  input  logic       s1_i,
  input  logic       s0_i,
  output logic [3:0] y_o
);

  // Select one of the eight data words by the 3-bit index
  always_comb begin
    y_o = a_i;
    case ({s2_i, s1_i, s0_i})
      3'd0:    y_o = a_i;
      3'd1:    y_o = b_i;
      3'd2:    y_o = c_i;
      3'd3:    y_o = d_i;
      3'd4:    y_o = e_i;
      3'd5:    y_o = f_i;
      3'd6:    y_o = g_i;
      3'd7:    y_o = h_i;
      default: y_o = a_i;
    endcase
  end

endmodule

module mx8_rr_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  mx8_rr_arbiter_if.slave   arb
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // beatCnt_q holds the number of beats already moved in this tenure.
  // It reaches LAST_BEAT just before the final allowed beat.
  localparam logic [3:0] LAST_BEAT = 4'(HOLD_MAX - 1);

  state_t     state_q;
  logic [7:0] grant_q;
  logic [2:0] sel_q;
  logic [2:0] ptr_q;
  logic [3:0] beatCnt_q;
  logic [3:0] y_q;
  logic       yValid_q;
  logic       busy_q;

  logic [3:0] muxOut;
  logic [2:0] winnerIdx;
  logic [2:0] scanIdx;
  logic       winnerFound;
  logic       ownerReq;
  logic       holdRelease;
  logic [2:0] nextPtr;

  // The shared mux is always steered by the registered selects. They are
  // kept through IDLE, so the mux input does not glitch between tenures.
  mx8_4bits u_mux (
    .a_i  (arb.a),
    .b_i  (arb.b),
    .c_i  (arb.c),
    .d_i  (arb.d),
    .e_i  (arb.e),
    .f_i  (arb.f),
    .g_i  (arb.g),
    .h_i  (arb.h),
    .s2_i (sel_q[2]),
    .s1_i (sel_q[1]),
    .s0_i (sel_q[0]),
    .y_o  (muxOut)
  );

  // Rotating priority scan: the first request found from ptr upward wins
  always_comb begin
    winnerIdx   = ptr_q;
    winnerFound = 1'b0;
    scanIdx     = ptr_q;
    for (int k = 0; k < 8; k++) begin
      scanIdx = ptr_q + 3'(k);
      if (!winnerFound && arb.req[scanIdx]) begin
        winnerIdx   = scanIdx;
        winnerFound = 1'b1;
      end
    end
  end

  // Owner's request bit, and the pointer position just past the owner
  assign ownerReq = arb.req[sel_q];
  assign nextPtr  = sel_q + 3'd1;

  // Decide whether the beat on this edge is the last one allowed
`ifdef MX8_ARB_LOCK_EN
  assign holdRelease = (beatCnt_q == LAST_BEAT) && !arb.lock;
`else
  assign holdRelease = (beatCnt_q == LAST_BEAT);
`endif

  // Arbitration FSM with registered outputs. Reset takes priority and
  // drops any beat in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= 8'd0;
      sel_q     <= 3'd0;
      ptr_q     <= 3'd0;
      beatCnt_q <= 4'd0;
      y_q       <= 4'd0;
      yValid_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          yValid_q <= 1'b0;
          if (winnerFound) begin
            grant_q   <= 8'd1 << winnerIdx;
            sel_q     <= winnerIdx;
            beatCnt_q <= 4'd0;
            busy_q    <= 1'b1;
            state_q   <= GRANT;
          end
        end

        GRANT: begin
          if (ownerReq) begin
            y_q      <= muxOut;
            yValid_q <= 1'b1;
            if (holdRelease) begin
              grant_q   <= 8'd0;
              busy_q    <= 1'b0;
              ptr_q     <= nextPtr;
              beatCnt_q <= 4'd0;
              state_q   <= IDLE;
            end else if (beatCnt_q != LAST_BEAT) begin
              beatCnt_q <= beatCnt_q + 4'd1;
            end
          end else begin
            yValid_q  <= 1'b0;
            grant_q   <= 8'd0;
            busy_q    <= 1'b0;
            ptr_q     <= nextPtr;
            beatCnt_q <= 4'd0;
            state_q   <= IDLE;
          end
        end

        default: begin
          state_q  <= IDLE;
          grant_q  <= 8'd0;
          yValid_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  // Drive the registered results onto the consumer side of the bus
  assign arb.grant   = grant_q;
  assign arb.s2      = sel_q[2];
  assign arb.s1      = sel_q[1];
  assign arb.s0      = sel_q[0];
  assign arb.y       = y_q;
  assign arb.y_valid = yValid_q;
  assign arb.busy    = busy_q;

endmodule

// File: tb/tb_mx8_rr_arbiter.sv
// tb_mx8_rr_arbiter
// Self-checking bench for mx8_rr_arbiter. A cycle-level reference model
// is built from the arbitration rules: a tenure owner, a count of beats,
// and a start position for the round-robin scan. The bench runs directed
// scenarios first, then randomized traffic.
// Optional feature macro: MX8_ARB_LOCK_EN, which adds the lock scenarios.
module tb_mx8_rr_arbiter;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic reset;

  mx8_rr_arbiter_if arbIf ();

  mx8_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (arbIf)
  );

  // Free-running clock
  always #5 clk = ~clk;

  int vecCount  = 0;
  int missCount = 0;

  logic [3:0] dataArr [8];
  logic       lockVal;

  // Reference model state
  int         mOwner;
  int         mBeats;
  int         mStart;
  logic [7:0] mGrant;
  logic [2:0] mSel;
  logic [3:0] mY;
  logic       mValid;
  logic       mBusy;

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecCount++;
    assert (obs === exp) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // End the current tenure and move the scan start just past the owner
  task automatic modelRelease();
    mStart = (mOwner + 1) % 8;
    mGrant = 8'd0;
    mBusy  = 1'b0;
    mOwner = -1;
  endtask

  // Advance the model by one rising edge using the inputs applied to it
  task automatic modelStep(input logic rst, input logic [7:0] reqV, input logic lk);
    if (rst) begin
      mOwner = -1; mBeats = 0; mStart = 0;
      mGrant = 8'd0; mSel = 3'd0; mY = 4'd0; mValid = 1'b0; mBusy = 1'b0;
    end else if (mOwner < 0) begin
      mValid = 1'b0;
      for (int k = 0; k < 8; k++) begin
        int cand;
        cand = (mStart + k) % 8;
        if (mOwner < 0 && reqV[cand]) mOwner = cand;
      end
      if (mOwner >= 0) begin
        mGrant = 8'd1 << mOwner;
        mSel   = 3'(mOwner);
        mBusy  = 1'b1;
        mBeats = 0;
      end
    end else if (reqV[mOwner]) begin
      mY     = dataArr[mOwner];
      mValid = 1'b1;
      mBeats++;
      if (mBeats >= HOLD && !lk) modelRelease();
    end else begin
      mValid = 1'b0;
      modelRelease();
    end
  endtask

  // Apply inputs, let one rising edge pass, then step the model for it
  task automatic applyStimulus(input logic rst, input logic [7:0] reqV);
    reset     = rst;
    arbIf.req = reqV;
    arbIf.a = dataArr[0]; arbIf.b = dataArr[1];
    arbIf.c = dataArr[2]; arbIf.d = dataArr[3];
    arbIf.e = dataArr[4]; arbIf.f = dataArr[5];
    arbIf.g = dataArr[6]; arbIf.h = dataArr[7];
`ifdef MX8_ARB_LOCK_EN
    arbIf.lock = lockVal;
`endif
    @(posedge clk);
`ifdef MX8_ARB_LOCK_EN
    modelStep(rst, reqV, lockVal);
`else
    modelStep(rst, reqV, 1'b0);
`endif
    #1;
  endtask

  // Compare every DUT output against the reference model
  task automatic checkOutput(input string tag);
    checkVal({tag, "_grant"}, arbIf.grant, mGrant);
    checkVal({tag, "_sel"}, {5'd0, arbIf.s2, arbIf.s1, arbIf.s0}, {5'd0, mSel});
    checkVal({tag, "_y"}, {4'd0, arbIf.y}, {4'd0, mY});
    checkVal({tag, "_valid"}, {7'd0, arbIf.y_valid}, {7'd0, mValid});
    checkVal({tag, "_busy"}, {7'd0, arbIf.busy}, {7'd0, mBusy});
  endtask

  initial begin
    int pulses;
    logic [7:0] reqR;

    lockVal = 1'b0;
    for (int i = 0; i < 8; i++) dataArr[i] = 4'(i);

    // 1: reset held two cycles with every requester active
    applyStimulus(1'b1, 8'hFF);
    applyStimulus(1'b1, 8'hFF);
    checkOutput("reset");
    checkVal("reset_grant_zero", arbIf.grant, 8'h00);
    checkVal("reset_busy_zero", {7'd0, arbIf.busy}, 8'h00);

    // 2: lone requester 2 with data A, repeated tenures with a bubble
    dataArr[2] = 4'hA;
    applyStimulus(1'b0, 8'h04);
    checkOutput("lone_grant");
    checkVal("lone_grant_onehot", arbIf.grant, 8'h04);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h04);
      checkOutput("lone_beat");
      if (arbIf.y_valid === 1'b1) pulses++;
    end
    checkVal("lone_pulse_count", 8'(pulses), 8'd4);
    checkVal("lone_released", arbIf.grant, 8'h00);
    applyStimulus(1'b0, 8'h04);
    checkOutput("lone_regrant");
    checkVal("lone_regrant_onehot", arbIf.grant, 8'h04);

    // 3: all requesting, data equals index, full rotation and wrap
    for (int i = 0; i < 8; i++) dataArr[i] = 4'(i);
    applyStimulus(1'b1, 8'h00);
    for (int i = 0; i < 45; i++) begin
      applyStimulus(1'b0, 8'hFF);
      checkOutput("rotate");
    end

    // 4: tenure of 7 ends, then 0 and 7 request -> pointer wrapped to 0
    applyStimulus(1'b1, 8'h00);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 8'h80);
      checkOutput("wrap_t7");
    end
    applyStimulus(1'b0, 8'h81);
    checkOutput("wrap_next");
    checkVal("wrap_grant", arbIf.grant, 8'h01);

    // 5: owner 3 drops its request after two beats
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b0, 8'h08);
    applyStimulus(1'b0, 8'h08);
    applyStimulus(1'b0, 8'h08);
    checkOutput("drop_beat2");
    applyStimulus(1'b0, 8'h00);
    checkOutput("drop_release");
    checkVal("drop_grant_zero", arbIf.grant, 8'h00);
    checkVal("drop_no_valid", {7'd0, arbIf.y_valid}, 8'h00);
    applyStimulus(1'b0, 8'hFF);
    checkVal("drop_ptr4", arbIf.grant, 8'h10);

    // 6: reset pulsed mid-tenure after beat 2
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b0, 8'h20);
    applyStimulus(1'b0, 8'h20);
    applyStimulus(1'b0, 8'h20);
    applyStimulus(1'b1, 8'h20);
    checkOutput("midreset");
    checkVal("midreset_y", {4'd0, arbIf.y}, 8'h00);
    checkVal("midreset_grant", arbIf.grant, 8'h00);

`ifdef MX8_ARB_LOCK_EN
    // Lock held: ten unbroken beats, then release once lock drops
    applyStimulus(1'b1, 8'h00);
    lockVal = 1'b1;
    applyStimulus(1'b0, 8'h02);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 8'h02);
      checkOutput("lock_beat");
      if (arbIf.y_valid === 1'b1) pulses++;
    end
    checkVal("lock_pulse_count", 8'(pulses), 8'd10);
    lockVal = 1'b0;
    applyStimulus(1'b0, 8'h02);
    checkOutput("lock_release");
`endif

    // Randomized traffic with sticky request patterns and rare resets
    reqR = 8'h00;
    applyStimulus(1'b1, 8'h00);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) reqR = 8'($urandom);
      for (int j = 0; j < 8; j++) dataArr[j] = 4'($urandom);
`ifdef MX8_ARB_LOCK_EN
      if ($urandom_range(0, 7) == 0) lockVal = 1'($urandom);
`endif
      applyStimulus($urandom_range(0, 99) == 0, reqR);
      checkOutput("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
